hazard_ctrl: RTL and testbench

- Parametrised hazard/forwarding controller for the five-stage MCU core.
- Replaces the constant `enable` and `rs1_depended` tie-offs in the core top.
- Tracks in-flight register writers in a scoreboard shift pipeline covering EXE..WB.
- Drives forwarding selects, load-use stalls, redirect flushes, data-memory wait freezes, and a wait-timeout flag.

---
 rtl/hazard_ctrl_if.sv | 62 ++++++
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Bundle between the core pipeline (master) and hazard_ctrl (slave).
// Perf-counter outputs exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if #(
    parameter int PIPE_DEPTH = 3,
    parameter int REG_IDX_W  = 5
);
    logic                  id_valid_i;
    logic [REG_IDX_W-1:0]  id_rs1_idx_i;
    logic                  id_rs1_used_i;
    logic [REG_IDX_W-1:0]  id_rs2_idx_i;
    logic                  id_rs2_used_i;
    logic [REG_IDX_W-1:0]  id_rd_idx_i;
    logic                  id_reg_write_en_i;
    logic                  id_is_load_i;
    logic                  redirect_i;
    logic                  dmem_busy_i;

    logic                  stall_f_o;
    logic                  stall_d_o;
    logic                  flush_d_o;
    logic                  flush_e_o;
    logic                  freeze_o;
    logic [PIPE_DEPTH-1:0] fwd_rs1_sel_o;
    logic [PIPE_DEPTH-1:0] fwd_rs2_sel_o;
    logic                  rs1_depended_o;
    logic                  rs2_depended_o;
    logic                  mem_timeout_o;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]           stall_cnt_o;
    logic [31:0]           freeze_cnt_o;
    logic [31:0]           flush_cnt_o;

    modport master (
        output id_valid_i, id_rs1_idx_i, id_rs1_used_i, id_rs2_idx_i, id_rs2_used_i,
               id_rd_idx_i, id_reg_write_en_i, id_is_load_i, redirect_i, dmem_busy_i,
        input  stall_f_o, stall_d_o, flush_d_o, flush_e_o, freeze_o,
               fwd_rs1_sel_o, fwd_rs2_sel_o, rs1_depended_o, rs2_depended_o, mem_timeout_o,
               stall_cnt_o, freeze_cnt_o, flush_cnt_o
    );
    modport slave (
        input  id_valid_i, id_rs1_idx_i, id_rs1_used_i, id_rs2_idx_i, id_rs2_used_i,
               id_rd_idx_i, id_reg_write_en_i, id_is_load_i, redirect_i, dmem_busy_i,
        output stall_f_o, stall_d_o, flush_d_o, flush_e_o, freeze_o,
               fwd_rs1_sel_o, fwd_rs2_sel_o, rs1_depended_o, rs2_depended_o, mem_timeout_o,
               stall_cnt_o, freeze_cnt_o, flush_cnt_o
    );
`else
    modport master (
        output id_valid_i, id_rs1_idx_i, id_rs1_used_i, id_rs2_idx_i, id_rs2_used_i,
               id_rd_idx_i, id_reg_write_en_i, id_is_load_i, redirect_i, dmem_busy_i,
        input  stall_f_o, stall_d_o, flush_d_o, flush_e_o, freeze_o,
               fwd_rs1_sel_o, fwd_rs2_sel_o, rs1_depended_o, rs2_depended_o, mem_timeout_o
    );
    modport slave (
        input  id_valid_i, id_rs1_idx_i, id_rs1_used_i, id_rs2_idx_i, id_rs2_used_i,
               id_rd_idx_i, id_reg_write_en_i, id_is_load_i, redirect_i, dmem_busy_i,
        output stall_f_o, stall_d_o, flush_d_o, flush_e_o, freeze_o,
               fwd_rs1_sel_o, fwd_rs2_sel_o, rs1_depended_o, rs2_depended_o, mem_timeout_o
    );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: writer scoreboard over EXE..WB, forwarding selects, load-use stall,
// redirect flush, memory-wait freeze and sticky timeout. HAZARD_PERF_CNT_EN adds event counters.
module hazard_ctrl #(
    parameter int PIPE_DEPTH   = 3,
    parameter int REG_IDX_W    = 5,
    parameter int MEM_WAIT_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    localparam int               CNT_W   = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);

    logic [PIPE_DEPTH-1:0] sb_valid_reg;
    logic [REG_IDX_W-1:0]  sb_rd_reg [PIPE_DEPTH];
    // Only the EXE slot ever consults the load flag, so older slots do not carry it.
    logic                  sb_load_reg;
    logic [CNT_W-1:0]      wait_cnt_reg;
    logic                  timeout_reg;

    logic [PIPE_DEPTH-1:0] rs1_match;
    logic [PIPE_DEPTH-1:0] rs2_match;
    logic [PIPE_DEPTH-1:0] rs1_first;
    logic [PIPE_DEPTH-1:0] rs2_first;
    logic                  rs1_load_use;
    logic                  rs2_load_use;
    logic                  load_use;
    logic                  freeze;
    logic                  record;

    generate
        for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_match
            assign rs1_match[gi] = hz.id_valid_i & hz.id_rs1_used_i & (hz.id_rs1_idx_i != '0)
                                 & sb_valid_reg[gi] & (sb_rd_reg[gi] == hz.id_rs1_idx_i);
            assign rs2_match[gi] = hz.id_valid_i & hz.id_rs2_used_i & (hz.id_rs2_idx_i != '0)
                                 & sb_valid_reg[gi] & (sb_rd_reg[gi] == hz.id_rs2_idx_i);
        end
    endgenerate

    // Isolate the lowest set bit: the youngest in-flight writer wins.
    assign rs1_first    = rs1_match & (~rs1_match + PIPE_DEPTH'(1));
    assign rs2_first    = rs2_match & (~rs2_match + PIPE_DEPTH'(1));
    assign rs1_load_use = rs1_first[0] & sb_load_reg;
    assign rs2_load_use = rs2_first[0] & sb_load_reg;
    assign load_use     = rs1_load_use | rs2_load_use;
    assign freeze       = hz.dmem_busy_i;
    assign record       = hz.id_valid_i & hz.id_reg_write_en_i & (hz.id_rd_idx_i != '0)
                        & ~load_use & ~hz.redirect_i;

    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_d;
    logic                  flush_e;
    logic                  freeze_out;
    logic [PIPE_DEPTH-1:0] fwd_rs1_sel;
    logic [PIPE_DEPTH-1:0] fwd_rs2_sel;
    logic                  mem_timeout;

    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        freeze_out  = 1'b0;
        fwd_rs1_sel = '0;
        fwd_rs2_sel = '0;
        mem_timeout = 1'b0;
        if (!reset) begin
            fwd_rs1_sel = rs1_load_use ? '0 : rs1_first;
            fwd_rs2_sel = rs2_load_use ? '0 : rs2_first;
            mem_timeout = timeout_reg | (freeze & (wait_cnt_reg == CNT_MAX));
            if (freeze) begin
                freeze_out = 1'b1;
                stall_f    = 1'b1;
                stall_d    = 1'b1;
            end else if (hz.redirect_i) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_valid_reg <= '0;
            sb_load_reg  <= 1'b0;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                sb_rd_reg[k] <= '0;
            end
        end else if (freeze) begin
            if (wait_cnt_reg == CNT_MAX) begin
                timeout_reg <= 1'b1;
            end else begin
                wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
            end
        end else begin
            wait_cnt_reg <= '0;
            sb_valid_reg <= {sb_valid_reg[PIPE_DEPTH-2:0], record};
            sb_load_reg  <= record & hz.id_is_load_i;
            sb_rd_reg[0] <= hz.id_rd_idx_i;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                sb_rd_reg[k] <= sb_rd_reg[k-1];
            end
        end
    end

    assign hz.stall_f_o      = stall_f;
    assign hz.stall_d_o      = stall_d;
    assign hz.flush_d_o      = flush_d;
    assign hz.flush_e_o      = flush_e;
    assign hz.freeze_o       = freeze_out;
    assign hz.fwd_rs1_sel_o  = fwd_rs1_sel;
    assign hz.fwd_rs2_sel_o  = fwd_rs2_sel;
    assign hz.rs1_depended_o = |fwd_rs1_sel;
    assign hz.rs2_depended_o = |fwd_rs2_sel;
    assign hz.mem_timeout_o  = mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] freeze_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg  <= '0;
            freeze_cnt_reg <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            if (freeze) begin
                freeze_cnt_reg <= freeze_cnt_reg + 32'd1;
            end
            if (!freeze && hz.redirect_i) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
            if (!freeze && !hz.redirect_i && load_use) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign hz.stall_cnt_o  = stall_cnt_reg;
    assign hz.freeze_cnt_o = freeze_cnt_reg;
    assign hz.flush_cnt_o  = flush_cnt_reg;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a queue-based model of in-flight writers checked every cycle,
// plus one hand-computed literal output word per vector.
module tb_hazard_ctrl;
    localparam int PD  = 3;
    localparam int RW  = 5;
    localparam int MWM = 4;

    // {stall_f, stall_d, flush_d, flush_e, freeze, timeout}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_RD   = 6'b001100;
    localparam logic [5:0] C_FZ   = 6'b110010;
    localparam logic [5:0] C_FZT  = 6'b110011;
    localparam logic [5:0] C_TO   = 6'b000001;

    logic clk = 1'b1;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.PIPE_DEPTH(PD), .REG_IDX_W(RW)) hif ();
    hazard_ctrl #(.PIPE_DEPTH(PD), .REG_IDX_W(RW), .MEM_WAIT_MAX(MWM)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    typedef struct {
        bit valid;
        int rd;
        bit load;
    } wr_t;

    wr_t   inflight[$];
    int    busy_run;
    bit    timeout_seen;
    int    n_checks = 0;
    int    n_fails  = 0;
    int    cyc      = 0;

    bit         lit_on;
    string      lit_name;
    logic [5:0] lit_ctrl;
    logic [2:0] lit_f1;
    logic [2:0] lit_f2;

    int         m1, m2;
    bit         lu;
    logic       e_sf, e_sd, e_fd, e_fe, e_fz, e_to;
    logic [2:0] e_f1, e_f2;

    function automatic int youngest(input int idx, input bit used);
        if (!hif.id_valid_i || !used || idx == 0) return -1;
        foreach (inflight[k]) begin
            if (inflight[k].valid && inflight[k].rd == idx) return k;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        cyc++;
        {e_sf, e_sd, e_fd, e_fe, e_fz, e_to} = 6'b0;
        e_f1 = '0;
        e_f2 = '0;
        if (!reset) begin
            m1 = youngest(int'(hif.id_rs1_idx_i), hif.id_rs1_used_i);
            m2 = youngest(int'(hif.id_rs2_idx_i), hif.id_rs2_used_i);
            lu = inflight[0].load && (m1 == 0 || m2 == 0);
            if (m1 >= 0 && !(m1 == 0 && inflight[0].load)) e_f1[m1] = 1'b1;
            if (m2 >= 0 && !(m2 == 0 && inflight[0].load)) e_f2[m2] = 1'b1;
            e_to = timeout_seen || (hif.dmem_busy_i && busy_run >= MWM);
            if (hif.dmem_busy_i) begin
                {e_sf, e_sd, e_fz} = 3'b111;
            end else if (hif.redirect_i) begin
                {e_fd, e_fe} = 2'b11;
            end else if (lu) begin
                {e_sf, e_sd, e_fe} = 3'b111;
            end
        end else begin
            lu = 1'b0;
        end

        check("stall_f",  32'(hif.stall_f_o),      32'(e_sf));
        check("stall_d",  32'(hif.stall_d_o),      32'(e_sd));
        check("flush_d",  32'(hif.flush_d_o),      32'(e_fd));
        check("flush_e",  32'(hif.flush_e_o),      32'(e_fe));
        check("freeze",   32'(hif.freeze_o),       32'(e_fz));
        check("timeout",  32'(hif.mem_timeout_o),  32'(e_to));
        check("fwd_rs1",  32'(hif.fwd_rs1_sel_o),  32'(e_f1));
        check("fwd_rs2",  32'(hif.fwd_rs2_sel_o),  32'(e_f2));
        check("dep_rs1",  32'(hif.rs1_depended_o), 32'(|e_f1));
        check("dep_rs2",  32'(hif.rs2_depended_o), 32'(|e_f2));
        if (lit_on) begin
            check({"lit_", lit_name},
                  32'({hif.stall_f_o, hif.stall_d_o, hif.flush_d_o, hif.flush_e_o, hif.freeze_o,
                       hif.mem_timeout_o, hif.fwd_rs1_sel_o, hif.fwd_rs2_sel_o,
                       hif.rs1_depended_o, hif.rs2_depended_o}),
                  32'({lit_ctrl, lit_f1, lit_f2, |lit_f1, |lit_f2}));
        end
        $display("cyc=%0d %s rst=%0b sf=%0b sd=%0b fd=%0b fe=%0b fz=%0b to=%0b f1=%b f2=%b",
                 cyc, lit_name, reset, hif.stall_f_o, hif.stall_d_o, hif.flush_d_o, hif.flush_e_o,
                 hif.freeze_o, hif.mem_timeout_o, hif.fwd_rs1_sel_o, hif.fwd_rs2_sel_o);

        // Advance the model to what the next clock edge must produce.
        if (reset) begin
            inflight.delete();
            repeat (PD) inflight.push_back('{valid: 1'b0, rd: 0, load: 1'b0});
            busy_run     = 0;
            timeout_seen = 1'b0;
        end else if (hif.dmem_busy_i) begin
            if (busy_run >= MWM) timeout_seen = 1'b1;
            busy_run++;
        end else begin
            busy_run = 0;
            inflight.push_front('{valid: hif.id_valid_i && hif.id_reg_write_en_i &&
                                         hif.id_rd_idx_i != 0 && !lu && !hif.redirect_i,
                                  rd: int'(hif.id_rd_idx_i), load: hif.id_is_load_i});
            void'(inflight.pop_back());
        end
    end

    task automatic vec(input bit rst, input bit v, input int rs1, input bit u1, input int rs2,
                       input bit u2, input int rd, input bit we, input bit ld, input bit redir,
                       input bit busy, input string name, input logic [5:0] ctrl,
                       input logic [2:0] f1, input logic [2:0] f2);
        reset                 = rst;
        hif.id_valid_i        = v;
        hif.id_rs1_idx_i      = RW'(rs1);
        hif.id_rs1_used_i     = u1;
        hif.id_rs2_idx_i      = RW'(rs2);
        hif.id_rs2_used_i     = u2;
        hif.id_rd_idx_i       = RW'(rd);
        hif.id_reg_write_en_i = we;
        hif.id_is_load_i      = ld;
        hif.redirect_i        = redir;
        hif.dmem_busy_i       = busy;
        lit_on                = 1'b1;
        lit_name              = name;
        lit_ctrl              = ctrl;
        lit_f1                = f1;
        lit_f2                = f2;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_vec();
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst", C_NONE, 3'b000, 3'b000);
    endtask

    initial begin
        // Reset state, including sources that would otherwise match
        vec(1, 1, 5, 1, 5, 1, 5, 1, 0, 0, 1, "rst_force0", C_NONE, 3'b000, 3'b000);
        rst_vec();
        // Forward from EXE
        vec(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, "wr_x5",     C_NONE, 3'b000, 3'b000);
        vec(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, "fwd_slot0", C_NONE, 3'b001, 3'b000);
        // One, two, three spacers
        rst_vec();
        vec(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, "wr_x5",     C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, "spacer6",   C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, "fwd_slot1", C_NONE, 3'b000, 3'b010);
        rst_vec();
        vec(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, "wr_x5",     C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, "spacer6",   C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, "spacer7",   C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, "fwd_slot2", C_NONE, 3'b000, 3'b100);
        rst_vec();
        vec(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, "wr_x5",     C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, "spacer6",   C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, "spacer7",   C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0, "spacer8",   C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, "retired",   C_NONE, 3'b000, 3'b000);
        // Youngest writer wins
        rst_vec();
        vec(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, "wr_x5a",    C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, "wr_x6",     C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, "wr_x5b",    C_NONE, 3'b000, 3'b000);
        vec(0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, "youngest",  C_NONE, 3'b001, 3'b010);
        // Load-use: one stall, then forward from MEM
        rst_vec();
        vec(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, "ld_x7",     C_NONE, 3'b000, 3'b000);
        vec(0, 1, 7, 1, 0, 0, 9, 1, 0, 0, 0, "lu_stall",  C_LU,   3'b000, 3'b000);
        vec(0, 1, 7, 1, 0, 0, 9, 1, 0, 0, 0, "lu_fwd",    C_NONE, 3'b010, 3'b000);
        // Load-use coincident with redirect
        rst_vec();
        vec(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, "ld_x7",     C_NONE, 3'b000, 3'b000);
        vec(0, 1, 7, 1, 0, 0, 9, 1, 0, 1, 0, "lu_redir",  C_RD,   3'b000, 3'b000);
        vec(0, 1, 9, 1, 7, 1, 0, 0, 0, 0, 0, "post_redir", C_NONE, 3'b000, 3'b010);
        // Memory wait: five busy cycles, timeout on the fifth
        rst_vec();
        vec(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, "wr_x5",     C_NONE, 3'b000, 3'b000);
        for (int i = 0; i < 4; i++) begin
            vec(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, "busy",  C_FZ,   3'b001, 3'b000);
        end
        vec(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, "busy_to",   C_FZT,  3'b001, 3'b000);
        vec(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, "unfreeze",  C_TO,   3'b001, 3'b000);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "to_sticky", C_TO,   3'b000, 3'b000);
        rst_vec();
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "to_clear",  C_NONE, 3'b000, 3'b000);
        // Broken busy runs must not accumulate
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "busy_a",    C_FZ,   3'b000, 3'b000);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "busy_a",    C_FZ,   3'b000, 3'b000);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "gap",       C_NONE, 3'b000, 3'b000);
        for (int i = 0; i < 4; i++) begin
            vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "busy_b", C_FZ,  3'b000, 3'b000);
        end
        // x0 never forwards; reset discards a full scoreboard
        rst_vec();
        vec(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "wr_x0",     C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, "rd_x0",     C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, "wr_x1",     C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, "wr_x2",     C_NONE, 3'b000, 3'b000);
        vec(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, "wr_x3",     C_NONE, 3'b000, 3'b000);
        vec(0, 1, 1, 1, 3, 1, 0, 0, 0, 0, 0, "full_sb",   C_NONE, 3'b100, 3'b001);
        vec(1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0, "rst_full",  C_NONE, 3'b000, 3'b000);
        vec(0, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, "post_rst",  C_NONE, 3'b000, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
